// File: rtl/regfile_sequencer.sv
// regfile_sequencer
//   Initiator side of a 2-read/1-write register-file port. Takes one
//   instruction per handshake, reads its two source registers, computes the
//   ALU result and writes it back, then reports the retirement.
//
//   Handshake: an instruction transfers on a rising edge where
//   in_valid && in_ready. in_ready is high only in IDLE; the source holds
//   in_valid/in_instr/in_imm stable until that edge. out_valid is a
//   one-cycle pulse with no back-pressure.
//
//   Ports
//     clk, rst              clock (rising edge), async active-low reset
//     in_valid, in_ready    instruction handshake
//     in_instr              {op[2:0], rd, rs1, rs2}
//     in_imm                immediate for LDI, sampled at accept
//     rf_r1, rf_r2          read ids to the register file
//     rf_v1, rf_v2          read data (registered, 1-cycle latency)
//     rf_w1, rf_w           write id (MSB=1 disables) and write data
//     out_valid/rd/result   retirement pulse, destination, result
//     dbg_state             current FSM state (IDLE=0, READ=1, EXEC=2)
//     flag_z, flag_c        zero / carry-borrow flags, only when the
//                           STATUS_FLAGS_EN macro is defined
module regfile_sequencer #(
    parameter int N = 32,
    parameter int M = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3+3*M-1:0] in_instr,
    input  logic [N-1:0]     in_imm,
    output logic [M-1:0]     rf_r1,
    output logic [M-1:0]     rf_r2,
    input  logic [N-1:0]     rf_v1,
    input  logic [N-1:0]     rf_v2,
    output logic [M:0]       rf_w1,
    output logic [N-1:0]     rf_w,
    output logic             out_valid,
    output logic [M-1:0]     out_rd,
    output logic [N-1:0]     out_result,
`ifdef STATUS_FLAGS_EN
    output logic             flag_z,
    output logic             flag_c,
`endif
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_MOV = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    state_t              state, state_nxt;
    logic [3+3*M-1:0]    instr_q;
    logic [N-1:0]        imm_q;
    logic [2:0]          op;
    logic [M-1:0]        rd, rs1, rs2;
    logic [N-1:0]        result;
    logic [N-1:0]        add_sum;

    assign op  = instr_q[3+3*M-1 -: 3];
    assign rd  = instr_q[3*M-1 -: M];
    assign rs1 = instr_q[2*M-1 -: M];
    assign rs2 = instr_q[M-1:0];

    assign dbg_state = state;

`ifdef STATUS_FLAGS_EN
    logic [N:0] sum_ext;
    logic       add_carry;
    assign sum_ext   = {1'b0, rf_v1} + {1'b0, rf_v2};
    assign add_sum   = sum_ext[N-1:0];
    assign add_carry = sum_ext[N];
`else
    assign add_sum = rf_v1 + rf_v2;
`endif

    // State register and the instruction/immediate latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            instr_q <= '0;
            imm_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                instr_q <= in_instr;
                imm_q   <= in_imm;
            end
        end
    end

    // ALU; only meaningful while in EXEC
    always_comb begin
        result = '0;
        case (op)
            OP_NOP: result = '0;
            OP_MOV: result = rf_v1;
            OP_ADD: result = add_sum;
            OP_SUB: result = rf_v1 - rf_v2;
            OP_AND: result = rf_v1 & rf_v2;
            OP_OR:  result = rf_v1 | rf_v2;
            OP_XOR: result = rf_v1 ^ rf_v2;
            OP_LDI: result = imm_q;
            default: result = '0;
        endcase
    end

    // Read ids follow the latched instruction; they only matter in READ,
    // and the latch clears to zero on reset.
    assign rf_r1 = rs1;
    assign rf_r2 = rs2;

    // Next state and outputs
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        rf_w1      = {1'b1, {M{1'b0}}};
        rf_w       = '0;
        out_valid  = 1'b0;
        out_rd     = '0;
        out_result = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = READ;
            end
            READ: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt  = IDLE;
                // NOP retires but keeps the write disabled
                if (op != OP_NOP) rf_w1 = {1'b0, rd};
                rf_w       = result;
                out_valid  = 1'b1;
                out_rd     = rd;
                out_result = result;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef STATUS_FLAGS_EN
    // Flags retire with the instruction; NOP and LDI leave them alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (state == EXEC && op != OP_NOP && op != OP_LDI) begin
            flag_z <= (result == '0);
            case (op)
                OP_ADD:  flag_c <= add_carry;
                OP_SUB:  flag_c <= (rf_v1 < rf_v2);
                default: flag_c <= 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;
  localparam int N = 32;
  localparam int M = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3+3*M-1:0] in_instr;
  logic [N-1:0]     in_imm;
  logic [M-1:0]     rf_r1, rf_r2;
  logic [N-1:0]     rf_v1, rf_v2;
  logic [M:0]       rf_w1;
  logic [N-1:0]     rf_w;
  logic             out_valid;
  logic [M-1:0]     out_rd;
  logic [N-1:0]     out_result;
  logic [1:0]       dbg_state;
`ifdef STATUS_FLAGS_EN
  logic             flag_z, flag_c;
`endif

  int tests = 0;
  int fails = 0;

  // clock / reset block
  always #5 clk = ~clk;

  regfile_sequencer #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm(in_imm),
    .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_v1(rf_v1), .rf_v2(rf_v2),
    .rf_w1(rf_w1), .rf_w(rf_w),
    .out_valid(out_valid), .out_rd(out_rd), .out_result(out_result),
`ifdef STATUS_FLAGS_EN
    .flag_z(flag_z), .flag_c(flag_c),
`endif
    .dbg_state(dbg_state)
  );

  // register file model: registered reads, write on rising edge
  logic [N-1:0] regs [4];
  initial for (int i = 0; i < 4; i++) regs[i] = '0;
  always @(posedge clk) begin
    rf_v1 <= regs[rf_r1];
    rf_v2 <= regs[rf_r2];
    if (!rf_w1[M]) regs[rf_w1[M-1:0]] <= rf_w;
  end

  // scoreboard of expected retirement results
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: wait for in_ready (bounded), then transfer one instruction
  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [N-1:0] imm);
    int budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_instr = {op, rd, rs1, rs2};
    in_imm   = imm;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // send one instruction and check the READ and EXEC cycles
  task automatic run(input string name, input logic [2:0] op, input logic [1:0] rd,
                     input logic [1:0] rs1, input logic [1:0] rs2, input logic [N-1:0] imm,
                     input logic [N-1:0] exp_res);
    exp_q.push_back(exp_res);
    send(op, rd, rs1, rs2, imm);
    @(negedge clk);
    check({name, "_read_ready"}, in_ready, 0);
    check({name, "_read_r1r2"}, {rf_r1, rf_r2}, {rs1, rs2});
    check({name, "_read_wdis"}, rf_w1[M], 1);
    @(negedge clk);
    check({name, "_exec_ready"}, in_ready, 0);
    check({name, "_exec_valid"}, out_valid, 1);
    check({name, "_exec_rd"}, out_rd, rd);
    check({name, "_exec_result"}, out_result, exp_q.pop_front());
    if (op == 3'b000) check({name, "_exec_wdis"}, rf_w1[M], 1);
    else begin
      check({name, "_exec_w1"}, rf_w1, {1'b0, rd});
      check({name, "_exec_w"}, rf_w, exp_res);
    end
  endtask

  task automatic check_flags(input string name, input logic z, input logic c);
`ifdef STATUS_FLAGS_EN
    @(posedge clk);
    #1;
    check({name, "_flag_z"}, flag_z, z);
    check({name, "_flag_c"}, flag_c, c);
`else
    if (z === c) begin end
`endif
  endtask

  initial begin
    logic [N-1:0] t5_exp [3];
    logic [8:0]   t5_ins [3];

    rst = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_imm = '0;
    #1;
    // 1: reset
    check("rst_ready", in_ready, 1);
    check("rst_w1", rf_w1, 3'b100);
    check("rst_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 2: LDI, LDI, ADD
    run("ldi_r1", 3'b111, 2'd1, 2'd0, 2'd0, 32'd5, 32'd5);
    run("ldi_r2", 3'b111, 2'd2, 2'd3, 2'd3, 32'd7, 32'd7);
    run("add_r3", 3'b010, 2'd3, 2'd1, 2'd2, 32'd0, 32'd12);
    check_flags("add_r3", 1'b0, 1'b0);

    // 3: SUB wraps negative, borrow set
    run("sub_r0", 3'b011, 2'd0, 2'd1, 2'd2, 32'd0, 32'hFFFF_FFFE);
    check_flags("sub_r0", 1'b0, 1'b1);

    // 4: ADD overflow, rd==rs1
    run("ldi_ff", 3'b111, 2'd1, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("ldi_one", 3'b111, 2'd2, 2'd0, 2'd0, 32'd1, 32'd1);
    run("add_wrap", 3'b010, 2'd1, 2'd1, 2'd2, 32'd0, 32'd0);
    check_flags("add_wrap", 1'b1, 1'b1);
    run("mov_r1", 3'b001, 2'd0, 2'd1, 2'd2, 32'd0, 32'd0);
    check_flags("mov_r1", 1'b1, 1'b0);

    // logic ops
    run("ldi_a", 3'b111, 2'd2, 2'd0, 2'd0, 32'hF0F0_1234, 32'hF0F0_1234);
    run("ldi_b", 3'b111, 2'd3, 2'd0, 2'd0, 32'h0FF0_00FF, 32'h0FF0_00FF);
    run("and", 3'b100, 2'd0, 2'd2, 2'd3, 32'd0, 32'h00F0_0034);
    run("or", 3'b101, 2'd0, 2'd2, 2'd3, 32'd0, 32'hFFF0_12FF);
    run("xor", 3'b110, 2'd0, 2'd2, 2'd3, 32'd0, 32'hFF00_12CB);
    check_flags("xor", 1'b0, 1'b0);
    run("nop", 3'b000, 2'd3, 2'd2, 2'd3, 32'd99, 32'd0);
    check_flags("nop", 1'b0, 1'b0);
    check("nop_keeps_r3", regs[3], 32'h0FF0_00FF);

    // 5: in_valid held for 9 cycles, three instructions
    t5_ins[0] = {3'b111, 2'd0, 2'd0, 2'd0}; t5_exp[0] = 32'd11;
    t5_ins[1] = {3'b111, 2'd1, 2'd0, 2'd0}; t5_exp[1] = 32'd22;
    t5_ins[2] = {3'b010, 2'd2, 2'd0, 2'd1}; t5_exp[2] = 32'd33;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      check($sformatf("hold_ready_%0d", cyc), in_ready, (cyc % 3) == 0);
      check($sformatf("hold_valid_%0d", cyc), out_valid, (cyc % 3) == 2);
      if (cyc % 3 == 2) check($sformatf("hold_result_%0d", cyc), out_result, t5_exp[cyc / 3]);
      in_valid = 1'b1;
      in_instr = t5_ins[cyc / 3];
      in_imm   = t5_exp[cyc / 3];
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_r2", regs[2], 32'd33);

    // 6: reset during READ of ADD r2,r1,r1
    send(3'b010, 2'd2, 2'd1, 2'd1, 32'd0);
    @(negedge clk);
    check("mid_in_read", dbg_state, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_wdis", rf_w1, 3'b100);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check("mid_rst_valid2", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_r2", regs[2], 32'd33);
    check("mid_rst_idle", dbg_state, 0);
`ifdef STATUS_FLAGS_EN
    check("mid_rst_flag_z", flag_z, 0);
    check("mid_rst_flag_c", flag_c, 0);
`endif
    run("mov_after", 3'b001, 2'd0, 2'd2, 2'd0, 32'd0, 32'd33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
